// File: rtl/ibex_prefetch_req_ctrl.sv
// rtl/ibex_prefetch_req_ctrl.sv - instruction fetch request controller feeding the IF-stage fetch FIFO
// Optional feature macro: IBEX_PREFETCH_ERR_HALT_EN (stop sequential fetching after a bus error until a branch)
module ibex_prefetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,

  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,

  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [NUM_REQS-1:0] out_shift, disc_shift;
  logic                stored_valid_q, stored_valid_d;
  logic [31:0]         stored_addr_q, stored_addr_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         branch_addr;
  logic                slot_free;
  logic                fifo_ready;
  logic                granted;
  logic                fetch_halt;

  assign fifo_ready  = ~&fifo_busy_i;
  assign slot_free   = ~outstanding_q[NUM_REQS-1];
  assign branch_addr = {addr_i[31:2], 2'b00};

  // A stored (ungranted) request must be held until granted, independent of req_i and FIFO space.
  assign instr_req_o  = slot_free &
                        ((req_i & ~fetch_halt & (fifo_ready | branch_i)) | stored_valid_q);
  assign instr_addr_o = branch_i       ? branch_addr   :
                        stored_valid_q ? stored_addr_q : fetch_addr_q;
  assign granted      = instr_req_o & instr_gnt_i;

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;

  assign busy_o = (|outstanding_q) | stored_valid_q;

  always_comb begin
    out_shift  = outstanding_q;
    disc_shift = discard_q;
    if (instr_rvalid_i) begin
      out_shift  = outstanding_q >> 1;
      disc_shift = discard_q >> 1;
    end
    if (branch_i) begin
      disc_shift = disc_shift | out_shift;
    end

    outstanding_d = out_shift;
    if (granted) begin
      outstanding_d = (out_shift << 1) | NUM_REQS'(1);
    end
    // Only slots that existed before this cycle may carry a discard mark.
    discard_d = disc_shift & out_shift;
  end

  always_comb begin
    stored_valid_d = stored_valid_q;
    stored_addr_d  = stored_addr_q;
    fetch_addr_d   = fetch_addr_q;
    if (granted) begin
      stored_valid_d = 1'b0;
      fetch_addr_d   = instr_addr_o + 32'd4;
    end else begin
      if (instr_req_o) begin
        stored_valid_d = 1'b1;
        stored_addr_d  = instr_addr_o;
      end
      if (branch_i) begin
        fetch_addr_d = branch_addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q  <= '0;
      discard_q      <= '0;
      stored_valid_q <= 1'b0;
      stored_addr_q  <= 32'h0;
      fetch_addr_q   <= 32'h0;
    end else begin
      outstanding_q  <= outstanding_d;
      discard_q      <= discard_d;
      stored_valid_q <= stored_valid_d;
      stored_addr_q  <= stored_addr_d;
      fetch_addr_q   <= fetch_addr_d;
    end
  end

`ifdef IBEX_PREFETCH_ERR_HALT_EN
  logic err_halt_q, err_halt_d;

  always_comb begin
    err_halt_d = err_halt_q;
    if (branch_i) begin
      err_halt_d = 1'b0;
    end else if (fifo_valid_o & instr_err_i) begin
      err_halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_halt_q <= 1'b0;
    end else begin
      err_halt_q <= err_halt_d;
    end
  end

  assign fetch_halt = err_halt_q & ~branch_i;
`else
  assign fetch_halt = 1'b0;
`endif

  assert property (@(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> outstanding_q[0])
    else $error("rvalid with no outstanding request");

endmodule

// File: tb/tb_ibex_prefetch_req_ctrl.sv
// tb/tb_ibex_prefetch_req_ctrl.sv - directed scoreboard bench for ibex_prefetch_req_ctrl
module tb_ibex_prefetch_req_ctrl;

  localparam int unsigned NUM_REQS = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                req_i, branch_i;
  logic [31:0]         addr_i;
  logic                busy_o;
  logic                fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic [31:0]         fifo_addr_o, fifo_rdata_o;
  logic [NUM_REQS-1:0] fifo_busy_i;
  logic                instr_req_o, instr_gnt_i;
  logic [31:0]         instr_addr_o;
  logic                instr_rvalid_i, instr_err_i;
  logic [31:0]         instr_rdata_i;

  ibex_prefetch_req_ctrl #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .busy_o         (busy_o),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .fifo_busy_i    (fifo_busy_i),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        disc;
  } ent_t;

  ent_t sb[$];
  logic b_stored;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the negedge, check combinational outputs, update the bench model, advance.
  task automatic step(input string tag, input logic req, input logic br, input logic [31:0] ba,
                      input logic gnt, input logic rv, input logic err, input logic [1:0] fb,
                      input logic exp_req, input logic [31:0] exp_addr);
    ent_t e;
    e.addr = 32'h0;
    e.disc = 1'b0;
    req_i          = req;
    branch_i       = br;
    addr_i         = ba;
    instr_gnt_i    = gnt;
    fifo_busy_i    = fb;
    instr_err_i    = err;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    if (rv) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
        e              = sb.pop_front();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_data(e.addr);
      end
    end
    #1;
    chk({tag, "_busy"}, 32'(busy_o), 32'((sb.size() != 0 || rv) || b_stored));
    chk({tag, "_req"}, 32'(instr_req_o), 32'(exp_req));
    if (exp_req) chk({tag, "_addr"}, instr_addr_o, exp_addr);
    chk({tag, "_clr"}, 32'(fifo_clear_o), 32'(br));
    if (br) chk({tag, "_faddr"}, fifo_addr_o, ba);
    chk({tag, "_fvalid"}, 32'(fifo_valid_o), 32'(instr_rvalid_i & ~e.disc & ~br));
    if (instr_rvalid_i) begin
      chk({tag, "_rdata"}, fifo_rdata_o, mem_data(e.addr));
      chk({tag, "_err"}, 32'(fifo_err_o), 32'(err));
    end
    if (br) begin
      foreach (sb[i]) sb[i].disc = 1'b1;
    end
    if (exp_req && gnt) begin
      e.addr = exp_addr;
      e.disc = 1'b0;
      sb.push_back(e);
      b_stored = 1'b0;
    end else if (exp_req) begin
      b_stored = 1'b1;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    b_stored       = 1'b0;
    rst_ni         = 1'b0;
    req_i          = 1'b0;
    branch_i       = 1'b0;
    addr_i         = 32'h0;
    fifo_busy_i    = '0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    instr_err_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_req", 32'(instr_req_o), 32'h0);
    chk("rst_fvalid", 32'(fifo_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    //    tag    req br ba            gnt rv err fb     exp_req exp_addr
    step("br1",  1, 1, 32'h0000_1002, 1, 0, 0, 2'b00, 1, 32'h0000_1000);
    step("seq1", 1, 0, 32'h0,         1, 1, 0, 2'b00, 1, 32'h0000_1004);
    step("seq2", 1, 0, 32'h0,         1, 1, 0, 2'b00, 1, 32'h0000_1008);
    step("stl0", 1, 0, 32'h0,         0, 1, 0, 2'b00, 1, 32'h0000_100C);
    step("stl1", 1, 0, 32'h0,         0, 0, 0, 2'b11, 1, 32'h0000_100C);
    step("stl2", 1, 0, 32'h0,         0, 0, 0, 2'b11, 1, 32'h0000_100C);
    step("stl3", 1, 0, 32'h0,         1, 0, 0, 2'b11, 1, 32'h0000_100C);
    step("full", 1, 0, 32'h0,         0, 0, 0, 2'b11, 0, 32'h0);
    step("rdy",  1, 0, 32'h0,         0, 1, 0, 2'b00, 1, 32'h0000_1010);
    step("br2",  1, 1, 32'h0000_2000, 1, 0, 0, 2'b00, 1, 32'h0000_2000);
    step("o2",   1, 0, 32'h0,         1, 0, 0, 2'b00, 1, 32'h0000_2004);
    step("max",  1, 0, 32'h0,         1, 0, 0, 2'b00, 0, 32'h0);
    step("br3",  1, 1, 32'h0000_3000, 0, 0, 0, 2'b00, 0, 32'h0);
    step("dsc1", 1, 0, 32'h0,         1, 1, 0, 2'b00, 0, 32'h0);
    step("dsc2", 1, 0, 32'h0,         1, 1, 0, 2'b00, 1, 32'h0000_3000);
    step("rg1",  1, 0, 32'h0,         1, 1, 0, 2'b00, 1, 32'h0000_3004);
    step("o3",   1, 0, 32'h0,         1, 0, 0, 2'b00, 1, 32'h0000_3008);
    step("rgf",  1, 0, 32'h0,         1, 1, 0, 2'b00, 0, 32'h0);
    step("drn",  0, 0, 32'h0,         0, 1, 0, 2'b00, 0, 32'h0);
    step("idle", 0, 0, 32'h0,         0, 0, 0, 2'b00, 0, 32'h0);

    step("e1",   1, 1, 32'h0000_4000, 1, 0, 0, 2'b00, 1, 32'h0000_4000);
    step("e2",   1, 0, 32'h0,         1, 1, 0, 2'b00, 1, 32'h0000_4004);
    step("e3",   1, 0, 32'h0,         0, 1, 1, 2'b00, 1, 32'h0000_4008);
    step("e4",   1, 0, 32'h0,         1, 0, 0, 2'b00, 1, 32'h0000_4008);
`ifdef IBEX_PREFETCH_ERR_HALT_EN
    step("e5",   1, 0, 32'h0,         0, 0, 0, 2'b00, 0, 32'h0);
`else
    step("e5",   1, 0, 32'h0,         0, 0, 0, 2'b00, 1, 32'h0000_400C);
`endif
    step("e6",   1, 1, 32'h0000_5002, 1, 1, 0, 2'b00, 1, 32'h0000_5000);
    step("e7",   0, 0, 32'h0,         0, 1, 0, 2'b00, 0, 32'h0);
    step("end",  0, 0, 32'h0,         0, 0, 0, 2'b00, 0, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
